// File: rtl/button_pkg.sv
// Shared types and default constants for the push-button count controller.
package button_pkg;

  // Controller states: idle, first-step hold, auto-repeat, and wait-for-release after a clear
  typedef enum logic [2:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    REP_UP,
    REP_DN,
    CLEAR_WAIT
  } bc_state_t;

  localparam int DEF_WIDTH           = 6;
  localparam int DEF_LED_W           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 120000;   // 10 ms at 12 MHz
  localparam int DEF_REPEAT_DELAY    = 6000000;  // 0.5 s at 12 MHz
  localparam int DEF_REPEAT_PERIOD   = 1200000;  // 0.1 s at 12 MHz

  // Width of the repeat timer: it only ever has to hold max(delay, period) - 1
  function automatic int timer_w(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int DEF_TIMER_W = timer_w(DEF_REPEAT_DELAY, DEF_REPEAT_PERIOD);

endpackage

// File: rtl/button_debounce.sv
// Synchroniser, debouncer and press detector for one raw push-button.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_a;
  logic             sync_b;
  logic             db_q;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous pin
  // NOTE: non-blocking assignments make sync_b take the old sync_a, giving two real stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Count consecutive cycles the synchronised level disagrees with db; flip db once the count is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync_b == db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
      cnt <= '0;
      db  <= ~db;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of db for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= 1'b0;
    end else begin
      db_q <= db;
    end
  end

  assign press = db & ~db_q;

endmodule

// File: rtl/button_ctrl.sv
// Two-button count controller: up/down step, auto-repeat on hold, clear when both are held.
module button_ctrl
  import button_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int LED_W           = DEF_LED_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       buttons,
  output logic [WIDTH-1:0] count,
  output logic [LED_W-1:0] led,
  output logic             step,
  output logic             dir,
  output logic             cleared
);

  localparam int RT_W = timer_w(REPEAT_DELAY, REPEAT_PERIOD);

  bc_state_t       state;
  logic [RT_W-1:0] rt;
  logic [RT_W-1:0] rt_limit;
  logic            db_up, db_dn;
  logic            press_up, press_dn;
  logic            hold_up, in_rep;
  logic            own_db, other_db;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (buttons[0]),
    .db      (db_up),
    .press   (press_up)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (buttons[1]),
    .db      (db_dn),
    .press   (press_dn)
  );

  // In the hold/repeat states, "own" is the button being held and "other" is the one that clears
  assign hold_up  = (state == HOLD_UP) || (state == REP_UP);
  assign in_rep   = (state == REP_UP)  || (state == REP_DN);
  assign own_db   = hold_up ? db_up : db_dn;
  assign other_db = hold_up ? db_dn : db_up;
  assign rt_limit = in_rep ? RT_W'(REPEAT_PERIOD - 1) : RT_W'(REPEAT_DELAY - 1);

  assign led = count[LED_W-1:0];

  // Controller FSM with registered count and pulse outputs; clear beats release beats repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rt      <= '0;
      count   <= '0;
      step    <= 1'b0;
      dir     <= 1'b1;
      cleared <= 1'b0;
    end else begin
      // NOTE: pulses default low here so every path below only has to raise them.
      step    <= 1'b0;
      cleared <= 1'b0;
      case (state)
        IDLE: begin
          rt <= '0;
          if (db_up && db_dn) begin
            count   <= '0;
            cleared <= 1'b1;
            state   <= CLEAR_WAIT;
          end else if (press_up) begin
            count <= count + WIDTH'(1);
            step  <= 1'b1;
            dir   <= 1'b1;
            state <= HOLD_UP;
          end else if (press_dn) begin
            count <= count - WIDTH'(1);
            step  <= 1'b1;
            dir   <= 1'b0;
            state <= HOLD_DN;
          end
        end

        HOLD_UP, HOLD_DN, REP_UP, REP_DN: begin
          if (other_db) begin
            rt      <= '0;
            count   <= '0;
            cleared <= 1'b1;
            state   <= CLEAR_WAIT;
          end else if (!own_db) begin
            rt    <= '0;
            state <= IDLE;
          end else if (rt == rt_limit) begin
            rt    <= '0;
            step  <= 1'b1;
            dir   <= hold_up;
            count <= hold_up ? count + WIDTH'(1) : count - WIDTH'(1);
            state <= hold_up ? REP_UP : REP_DN;
          end else begin
            rt <= rt + RT_W'(1);
          end
        end

        CLEAR_WAIT: begin
          rt <= '0;
          if (!db_up && !db_dn) begin
            state <= IDLE;
          end
        end

        default: begin
          rt    <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model built from the button rules.
module tb_button_ctrl;

  localparam int W  = 6;
  localparam int LW = 4;
  localparam int D  = 4;
  localparam int RD = 16;
  localparam int RP = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    buttons = 2'b00;
  logic [W-1:0]  count;
  logic [LW-1:0] led;
  logic          step, dir, cleared;

  button_ctrl #(
    .WIDTH(W), .LED_W(LW), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons),
    .count(count), .led(led), .step(step), .dir(dir), .cleared(cleared)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the user sees, not how the RTL is built
  typedef enum int {M_IDLE, M_UP, M_DN, M_CLR} mode_t;
  mode_t        m_mode;
  int           m_age;       // cycles since the step that started the current hold
  logic [W-1:0] m_count;
  logic         m_step, m_clr, m_dir;
  logic [1:0]   m_db, m_db_q;
  logic [1:0]   hist[$];     // recent pin samples, oldest first

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode  = M_IDLE;
    m_age   = 0;
    m_count = '0;
    m_step  = 1'b0;
    m_clr   = 1'b0;
    m_dir   = 1'b1;
    m_db    = 2'b00;
    m_db_q  = 2'b00;
    hist.delete();
  endfunction

  function automatic bit repeat_due(int k);
    return (k == RD) || (k > RD && ((k - RD) % RP) == 0);
  endfunction

  function automatic void model_bump(bit up);
    m_count = up ? m_count + W'(1) : m_count - W'(1);
    m_step  = 1'b1;
    m_dir   = up;
  endfunction

  function automatic void model_clear();
    m_count = '0;
    m_clr   = 1'b1;
    m_mode  = M_CLR;
  endfunction

  // One clock edge: decide from the debounced levels seen before the edge, then update them
  function automatic void model_edge(logic [1:0] pins);
    logic [1:0] pr;
    int         own;
    bit         all_differ;
    pr     = m_db & ~m_db_q;
    m_step = 1'b0;
    m_clr  = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (m_db == 2'b11) model_clear();
        else if (pr[0]) begin model_bump(1'b1); m_mode = M_UP; m_age = 0; end
        else if (pr[1]) begin model_bump(1'b0); m_mode = M_DN; m_age = 0; end
      end
      M_UP, M_DN: begin
        own = (m_mode == M_UP) ? 0 : 1;
        if (m_db[1-own]) model_clear();
        else if (!m_db[own]) m_mode = M_IDLE;
        else begin
          m_age++;
          if (repeat_due(m_age)) model_bump(own == 0);
        end
      end
      default: begin
        if (m_db == 2'b00) m_mode = M_IDLE;
      end
    endcase
    // A level change is accepted once D+1 consecutive pin samples, seen through the
    // two-cycle synchroniser delay, all disagree with the current debounced level.
    m_db_q = m_db;
    hist.push_back(pins);
    if (hist.size() > D + 3) void'(hist.pop_front());
    if (hist.size() == D + 3) begin
      for (int b = 0; b < 2; b++) begin
        all_differ = 1'b1;
        for (int i = 0; i <= D; i++)
          if (hist[i][b] == m_db[b]) all_differ = 1'b0;
        if (all_differ) m_db[b] = ~m_db[b];
      end
    end
  endfunction

  task automatic compare();
    check("count", 32'(count), 32'(m_count));
    check("led", 32'(led), 32'(m_count[LW-1:0]));
    check("step", 32'(step), 32'(m_step));
    check("dir", 32'(dir), 32'(m_dir));
    check("cleared", 32'(cleared), 32'(m_clr));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge(buttons);
    #1;
    compare();
  endtask

  task automatic run(logic [1:0] b, int n);
    buttons = b;
    repeat (n) cycle();
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must clear before the next edge
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_count", 32'(count), 32'd0);
    compare();
    cycle();
    rst_n = 1'b1;
  endtask

  int         steps_seen;
  int         clears_seen;
  int         step_edges[$];
  logic [1:0] rb;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_dir", 32'(dir), 32'd1);
    check("reset_step", 32'(step), 32'd0);
    check("reset_cleared", 32'(cleared), 32'd0);
    compare();
    rst_n = 1'b1;
    run(2'b00, 3);

    // Short press: first step exactly D+3 edges after the first high sample
    buttons = 2'b01;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t1_step_timing", 32'(step), 32'(i == D + 3));
    end
    run(2'b00, 20);
    check("t1_count", 32'(count), 32'd1);
    check("t1_led", 32'(led), 32'h1);
    check("t1_dir", 32'(dir), 32'd1);

    // Glitches shorter than the debounce window are ignored
    for (int g = 0; g < 5; g++) begin
      run(2'b01, 3);
      run(2'b00, 2);
    end
    run(2'b00, 10);
    check("t2_count", 32'(count), 32'd1);

    // Long hold: first step, then delay, then period
    step_edges.delete();
    buttons = 2'b01;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (step) step_edges.push_back(i);
    end
    check("t3_nsteps", 32'(step_edges.size()), 32'd6);
    if (step_edges.size() >= 3) begin
      check("t3_first", 32'(step_edges[0]), 32'(D + 3));
      check("t3_second", 32'(step_edges[1]), 32'(D + 3 + RD));
      check("t3_third", 32'(step_edges[2]), 32'(D + 3 + RD + RP));
    end
    run(2'b00, 25);

    // Wrap in both directions from a freshly reset counter
    do_reset();
    run(2'b00, 2);
    run(2'b10, 8);
    run(2'b00, 12);
    check("t4_wrap_down", 32'(count), 32'd63);
    check("t4_led", 32'(led), 32'hF);
    check("t4_dir", 32'(dir), 32'd0);
    steps_seen = 0;
    buttons = 2'b01;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (step) steps_seen++;
      if (i == 7) buttons = 2'b00;
    end
    check("t4_wrap_up", 32'(count), 32'd0);
    check("t4_wrap_step", 32'(steps_seen), 32'd1);

    // Hold up, add down: one clear pulse, no step; clear waits for both releases
    run(2'b01, 10);
    steps_seen  = 0;
    clears_seen = 0;
    buttons = 2'b11;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (step) steps_seen++;
      if (cleared) clears_seen++;
    end
    check("t5_clear_pulses", 32'(clears_seen), 32'd1);
    check("t5_no_step", 32'(steps_seen), 32'd0);
    check("t5_count", 32'(count), 32'd0);
    run(2'b10, 15);
    check("t5_partial_release", 32'(count), 32'd0);
    run(2'b00, 15);
    run(2'b01, 8);
    run(2'b00, 12);
    check("t5_after_clear", 32'(count), 32'd1);

    // Reset in the middle of auto-repeat with the button still held
    do_reset();
    run(2'b00, 2);
    run(2'b01, 40);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t6_step_timing", 32'(step), 32'(i == D + 3));
    end
    check("t6_count", 32'(count), 32'd1);
    run(2'b00, 20);

    // Random button traffic, with the occasional reset
    for (int s = 0; s < 80; s++) begin
      rb = 2'($urandom_range(0, 3));
      run(rb, int'($urandom_range(1, 30)));
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    run(2'b00, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
